// File: rtl/pop_buttons_pkg.sv
// -----------------------------------------------------------------------------
// pop_buttons_pkg
// Shared definitions for the front-panel button conditioner:
//   - button index constants (bit order of the btn_* buses)
//   - default timing constants for a 2.5 MHz clock and 100 us debounce tick
//   - repeat FSM state encoding
//   - small constant-width helpers used to size counters
// -----------------------------------------------------------------------------
package pop_buttons_pkg;

    // Button bit positions on btn_n / btn_level / btn_press / btn_repeat
    localparam int BTN_MODE = 0;
    localparam int BTN_LOAD = 1;
    localparam int BTN_TL   = 2;
    localparam int BTN_TR   = 3;
    localparam int BTN_BL   = 4;
    localparam int BTN_BR   = 5;

    // Default timing: 250 x 400 ns = 100 us tick
    localparam int N_BTN_DEF              = 6;
    localparam int TICK_DIV_DEF           = 250;
    localparam int STABLE_TICKS_DEF       = 200;   // 20 ms
    localparam int REPEAT_DELAY_TICKS_DEF = 5000;  // 500 ms
    localparam int REPEAT_RATE_TICKS_DEF  = 1000;  // 100 ms

    typedef enum logic [1:0] {
        RPT_RELEASED  = 2'd0,
        RPT_DELAY     = 2'd1,
        RPT_REPEATING = 2'd2
    } rpt_state_e;

    // Bits needed to hold values 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One front-panel button: two-flop inverting synchroniser, tick-based
// debounce counter, press pulse and (optionally) the auto-repeat FSM.
// The debounce tick comes from the shared prescaler in the parent.
//
// Build option: BUTTON_AUTOREPEAT_EN -- when undefined the repeat FSM and its
// counter are not built and rpt is tied low.
//
// Ports:
//   clk_2M5  in   system clock
//   reset    in   synchronous, active-high
//   tick     in   one-cycle debounce tick
//   raw_n    in   raw button, asynchronous, low = pressed
//   level    out  debounced state, high = pressed
//   press    out  one-cycle pulse on each accepted press
//   rpt      out  one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_channel
    import pop_buttons_pkg::*;
#(
    parameter int STABLE_TICKS       = STABLE_TICKS_DEF,
    parameter int REPEAT_DELAY_TICKS = REPEAT_DELAY_TICKS_DEF,
    parameter int REPEAT_RATE_TICKS  = REPEAT_RATE_TICKS_DEF
) (
    input  logic clk_2M5,
    input  logic reset,
    input  logic tick,
    input  logic raw_n,
    output logic level,
    output logic press,
    output logic rpt
);

    localparam int ST_W = cnt_width(STABLE_TICKS);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_TICKS);

    logic            sync1_r;
    logic            sync2_r;
    logic [ST_W-1:0] stable_cnt_r;
    logic [ST_W-1:0] stable_inc_s;
    logic            accept_s;
    logic            level_r;
    logic            press_r;

    // Debounce decision: accept a change on the tick that completes the run
    always_comb begin
        stable_inc_s = stable_cnt_r + ST_W'(1);
        if (tick && (sync2_r != level_r) && (stable_inc_s == ST_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Synchroniser, stable counter, debounced level and press pulse
    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            stable_cnt_r <= {ST_W{1'b0}};
            level_r      <= 1'b0;
            press_r      <= 1'b0;
        end else begin
            sync1_r <= ~raw_n;
            sync2_r <= sync1_r;
            // press is raised on the same edge that level rises
            press_r <= accept_s & sync2_r;
            if (sync2_r == level_r) begin
                // any agreeing cycle restarts the run, so glitches never accumulate
                stable_cnt_r <= {ST_W{1'b0}};
            end else if (accept_s) begin
                stable_cnt_r <= {ST_W{1'b0}};
                level_r      <= sync2_r;
            end else if (tick) begin
                stable_cnt_r <= stable_inc_s;
            end else begin
                stable_cnt_r <= stable_cnt_r;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RP_W = cnt_width(max_int(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS));
    localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY_TICKS);
    localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE_TICKS);

    rpt_state_e      rpt_state_r;
    logic [RP_W-1:0] rpt_cnt_r;
    logic [RP_W-1:0] rpt_inc_s;
    logic            rpt_r;
    logic            rise_s;
    logic            fall_s;

    // Level edges are taken from the accept decision so the FSM moves on the
    // same edge the level changes
    always_comb begin
        rise_s    = accept_s & sync2_r;
        fall_s    = accept_s & ~sync2_r;
        rpt_inc_s = rpt_cnt_r + RP_W'(1);
    end

    // Repeat FSM: hold delay, then periodic pulses; a fall always wins
    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            rpt_state_r <= RPT_RELEASED;
            rpt_cnt_r   <= {RP_W{1'b0}};
            rpt_r       <= 1'b0;
        end else begin
            rpt_r <= 1'b0;
            if (fall_s) begin
                rpt_state_r <= RPT_RELEASED;
                rpt_cnt_r   <= {RP_W{1'b0}};
            end else begin
                case (rpt_state_r)
                    RPT_RELEASED: begin
                        if (rise_s) begin
                            rpt_state_r <= RPT_DELAY;
                            rpt_cnt_r   <= {RP_W{1'b0}};
                        end
                    end
                    RPT_DELAY: begin
                        if (tick) begin
                            if (rpt_inc_s == RP_DELAY_LAST) begin
                                rpt_r       <= 1'b1;
                                rpt_cnt_r   <= {RP_W{1'b0}};
                                rpt_state_r <= RPT_REPEATING;
                            end else begin
                                rpt_cnt_r <= rpt_inc_s;
                            end
                        end
                    end
                    RPT_REPEATING: begin
                        if (tick) begin
                            if (rpt_inc_s == RP_RATE_LAST) begin
                                rpt_r     <= 1'b1;
                                rpt_cnt_r <= {RP_W{1'b0}};
                            end else begin
                                rpt_cnt_r <= rpt_inc_s;
                            end
                        end
                    end
                    default: begin
                        rpt_state_r <= RPT_RELEASED;
                        rpt_cnt_r   <= {RP_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign rpt = rpt_r;
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Front-panel button conditioner feeding the POP timing core and mode FSM.
// A shared prescaler produces the 100 us debounce tick; one button_channel per
// button synchronises, debounces and generates press / auto-repeat pulses.
//
// Build option: BUTTON_AUTOREPEAT_EN -- enables the per-channel auto-repeat
// FSM; when undefined btn_repeat is constant 0.
//
// Ports:
//   clk_2M5     in   2.5 MHz system clock
//   reset       in   synchronous, active-high
//   btn_n       in   raw buttons, asynchronous, low = pressed
//                    (bit order: mode, load_defaults, TL, TR, BL, BR)
//   btn_level   out  debounced state, high = pressed
//   btn_press   out  one-cycle pulse on each accepted press
//   btn_repeat  out  one-cycle auto-repeat pulses while held
//   tick_100us  out  one-cycle debounce tick for other slow logic
// -----------------------------------------------------------------------------
module button_conditioner
    import pop_buttons_pkg::*;
#(
    parameter int N_BTN              = N_BTN_DEF,
    parameter int TICK_DIV           = TICK_DIV_DEF,
    parameter int STABLE_TICKS       = STABLE_TICKS_DEF,
    parameter int REPEAT_DELAY_TICKS = REPEAT_DELAY_TICKS_DEF,
    parameter int REPEAT_RATE_TICKS  = REPEAT_RATE_TICKS_DEF
) (
    input  logic             clk_2M5,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             tick_100us
);

    localparam int PRE_W = cnt_width(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_r;
    logic [PRE_W-1:0] pre_cnt_next_s;
    logic             tick_r;

    // Prescaler next count, wrapping at TICK_DIV-1
    always_comb begin
        if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_next_s = {PRE_W{1'b0}};
        end else begin
            pre_cnt_next_s = pre_cnt_r + PRE_W'(1);
        end
    end

    // Prescaler and tick; tick is registered so it is high exactly while the
    // count sits at TICK_DIV-1
    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            tick_r    <= 1'b0;
        end else begin
            pre_cnt_r <= pre_cnt_next_s;
            tick_r    <= (pre_cnt_next_s == PRE_LAST);
        end
    end

    assign tick_100us = tick_r;

    for (genvar i = 0; i < N_BTN; i++) begin : gen_ch
        button_channel #(
            .STABLE_TICKS       (STABLE_TICKS),
            .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
        ) u_ch (
            .clk_2M5 (clk_2M5),
            .reset   (reset),
            .tick    (tick_r),
            .raw_n   (btn_n[i]),
            .level   (btn_level[i]),
            .press   (btn_press[i]),
            .rpt     (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner with TICK_DIV=4, STABLE_TICKS=3,
// REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2. Expected press / repeat / level
// edges are computed from the stimulus timing and queued; a monitor on the
// falling clock edge matches every observed event against that queue.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NB = 6;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RR = 2;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif
    localparam int K_PRESS = 0;
    localparam int K_REP   = 1;
    localparam int K_RISE  = 2;
    localparam int K_FALL  = 3;

    logic          clk_2M5 = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_repeat;
    logic          tick_100us;

    always #5 clk_2M5 = ~clk_2M5;

    button_conditioner #(
        .N_BTN              (NB),
        .TICK_DIV           (TD),
        .STABLE_TICKS       (ST),
        .REPEAT_DELAY_TICKS (RD),
        .REPEAT_RATE_TICKS  (RR)
    ) dut (
        .clk_2M5    (clk_2M5),
        .reset      (reset),
        .btn_n      (btn_n),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_repeat (btn_repeat),
        .tick_100us (tick_100us)
    );

    typedef struct {
        int edge_n;
        int ch;
        int kind;
    } ev_t;

    typedef struct {
        logic [NB-1:0] mask;
        int            hold;
        int            exp_press;
        int            exp_rep;
    } vec_t;

    ev_t           exp_q[$];
    vec_t          vecs[7];
    int            edge_cnt = 0;
    logic          rst_q = 1'b0;
    int            rel_edge = 0;   // last edge at which reset was sampled high
    int            total = 0;
    int            bad = 0;
    bit            mon_en = 1'b0;
    logic [NB-1:0] prev_level = '0;
    int            press_cnt[NB];
    int            rep_cnt[NB];

    always @(posedge clk_2M5) begin
        edge_cnt <= edge_cnt + 1;
        rst_q    <= reset;
    end

    // first edge >= e at which the channels see tick_100us high
    function automatic int nt(input int e);
        int m;
        m = (e - rel_edge + TD - 1) / TD;
        if (m < 1) m = 1;
        return rel_edge + m * TD;
    endfunction

    task automatic push(input int n, input int ch, input int kind);
        ev_t ev;
        ev.edge_n = n;
        ev.ch     = ch;
        ev.kind   = kind;
        exp_q.push_back(ev);
    endtask

    // button ch pressed from edge k, released from edge j
    task automatic push_hold(input int ch, input int k, input int j);
        int p, f, r;
        p = nt(k + 2) + (ST - 1) * TD;
        if (p <= j + 1) begin
            push(p, ch, K_PRESS);
            push(p, ch, K_RISE);
            f = nt(j + 2) + (ST - 1) * TD;
            push(f, ch, K_FALL);
`ifdef BUTTON_AUTOREPEAT_EN
            r = p + RD * TD;
            while (r < f) begin
                push(r, ch, K_REP);
                r += RR * TD;
            end
`else
            r = 0;
`endif
        end
    endtask

    task automatic check_ev(input int n, input int ch, input int kind, input string nm);
        int idx;
        idx = -1;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].edge_n == n && exp_q[i].ch == ch && exp_q[i].kind == kind)
                idx = i;
        end
        total++;
        if (idx >= 0) begin
            exp_q.delete(idx);
        end else begin
            bad++;
            $display("FAIL %s ch%0d: event observed at edge %0d, required none there", nm, ch, n);
        end
    endtask

    // Monitor: outputs sampled half a cycle after the active edge
    always @(negedge clk_2M5) begin
        if (mon_en) begin
            total++;
            if (rst_q) begin
                if ({tick_100us, btn_level, btn_press, btn_repeat} != '0) begin
                    bad++;
                    $display("FAIL reset_outputs edge %0d: tick=%b level=%b press=%b repeat=%b, required all 0",
                             edge_cnt, tick_100us, btn_level, btn_press, btn_repeat);
                end
            end else begin
                if (tick_100us != (((edge_cnt - rel_edge) % TD) == TD - 1)) begin
                    bad++;
                    $display("FAIL tick edge %0d: got %b, required %b", edge_cnt, tick_100us,
                             (((edge_cnt - rel_edge) % TD) == TD - 1));
                end
            end
            for (int ch = 0; ch < NB; ch++) begin
                if (btn_press[ch]) begin
                    press_cnt[ch]++;
                    check_ev(edge_cnt, ch, K_PRESS, "press");
                end
                if (btn_repeat[ch]) begin
                    rep_cnt[ch]++;
                    check_ev(edge_cnt, ch, K_REP, "repeat");
                end
                if (btn_level[ch] && !prev_level[ch]) check_ev(edge_cnt, ch, K_RISE, "level_rise");
                if (!btn_level[ch] && prev_level[ch]) check_ev(edge_cnt, ch, K_FALL, "level_fall");
            end
            prev_level = btn_level;
        end
    end

    // Expected events whose edge has already been monitored are missing
    task automatic drain();
        ev_t keep[$];
        foreach (exp_q[i]) begin
            if (exp_q[i].edge_n < edge_cnt) begin
                total++;
                bad++;
                $display("FAIL missing_event ch%0d kind%0d: nothing observed, required at edge %0d",
                         exp_q[i].ch, exp_q[i].kind, exp_q[i].edge_n);
            end else begin
                keep.push_back(exp_q[i]);
            end
        end
        exp_q = keep;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_2M5);
    endtask

    // next drive takes effect on a tick edge
    task automatic align();
        for (int i = 0; i < TD; i++) begin
            if (((edge_cnt + 1 - rel_edge) % TD) != 0) @(negedge clk_2M5);
        end
    endtask

    task automatic clr_cnt();
        for (int ch = 0; ch < NB; ch++) begin
            press_cnt[ch] = 0;
            rep_cnt[ch]   = 0;
        end
    endtask

    task automatic check_counts(input string nm, input logic [NB-1:0] mask,
                                input int ep, input int er);
        int e;
        for (int ch = 0; ch < NB; ch++) begin
            e = mask[ch] ? ep : 0;
            total++;
            if (press_cnt[ch] != e) begin
                bad++;
                $display("FAIL %s press_count ch%0d: got %0d, required %0d", nm, ch, press_cnt[ch], e);
            end
            e = mask[ch] ? er * AR : 0;
            total++;
            if (rep_cnt[ch] != e) begin
                bad++;
                $display("FAIL %s repeat_count ch%0d: got %0d, required %0d", nm, ch, rep_cnt[ch], e);
            end
        end
    endtask

    initial begin
        int k, j, p, e;

        // {mask, hold cycles from a tick-aligned press, presses, repeats when enabled}
        vecs[0] = '{6'b000100, 40,  1, 3};   // clean press on TL
        vecs[1] = '{6'b000001, 16,  1, 0};   // released during DELAY
        vecs[2] = '{6'b001000, 240, 1, 28};  // 60 ticks held: auto-repeat
        vecs[3] = '{6'b111111, 24,  1, 1};   // all six together
        vecs[4] = '{6'b000010, 10,  0, 0};   // glitch one cycle too short
        vecs[5] = '{6'b000010, 11,  1, 0};   // shortest accepted press
        vecs[6] = '{6'b110000, 52,  1, 4};   // fall coincides with repeat terminal count

        reset = 1'b1;
        btn_n = '1;
        clr_cnt();
        cyc(3);
        mon_en = 1'b1;
        @(negedge clk_2M5);
        rel_edge = edge_cnt;
        reset    = 1'b0;
        cyc(5);

        foreach (vecs[v]) begin
            clr_cnt();
            align();
            k = edge_cnt + 1;
            btn_n = ~vecs[v].mask;
            for (int ch = 0; ch < NB; ch++)
                if (vecs[v].mask[ch]) push_hold(ch, k, k + vecs[v].hold);
            cyc(vecs[v].hold);
            btn_n = '1;
            cyc(30);
            drain();
            check_counts($sformatf("vec%0d", v), vecs[v].mask, vecs[v].exp_press, vecs[v].exp_rep);
        end

        // Bounce on mode: toggles every 5 cycles for 40 cycles, then held
        clr_cnt();
        align();
        for (int seg = 0; seg < 8; seg++) begin
            k = edge_cnt + 1;
            btn_n[0] = (seg % 2 == 1) ? 1'b1 : 1'b0;
            if (seg % 2 == 0) push_hold(0, k, k + 5);
            cyc(5);
        end
        k = edge_cnt + 1;
        btn_n[0] = 1'b0;
        push_hold(0, k, k + 20);
        cyc(20);
        btn_n[0] = 1'b1;
        cyc(30);
        drain();
        check_counts("bounce", 6'b000001, 1, 0);

        // Reset while TR is repeating, button kept held through reset
        clr_cnt();
        align();
        k = edge_cnt + 1;
        btn_n[3] = 1'b0;
        p = nt(k + 2) + (ST - 1) * TD;
        push(p, 3, K_PRESS);
        push(p, 3, K_RISE);
        cyc(44);
        e = edge_cnt + 1;
`ifdef BUTTON_AUTOREPEAT_EN
        for (int r = p + RD * TD; r < e; r += RR * TD) push(r, 3, K_REP);
`endif
        push(e, 3, K_FALL);
        reset = 1'b1;
        cyc(2);
        rel_edge = edge_cnt;
        reset    = 1'b0;
        k = edge_cnt + 1;
        j = k + 40;
        push_hold(3, k, j);
        cyc(40);
        btn_n = '1;
        cyc(30);
        drain();
        check_counts("reset_held", 6'b001000, 2, 5);

        cyc(5);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
